// File: rtl/writeback_unit.sv
// Writeback stage: sole driver of the register-file write port. ALU results
// retire in one cycle; loads wait for the memory response, then align and extend.
module writeback_unit #(
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_REGISTER = 32,
    localparam int AW          = $clog2(NUM_REGISTER)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  ex_valid_i,
    output logic                  ex_ready_o,
    input  logic                  ex_wb_en_i,
    input  logic                  ex_is_load_i,
    input  logic [2:0]            ex_funct3_i,
    input  logic [1:0]            ex_byte_off_i,
    input  logic [AW-1:0]         ex_rd_addr_i,
    input  logic [DATA_WIDTH-1:0] ex_result_i,
    input  logic                  mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0] mem_rdata_i,
    input  logic                  mem_err_i,
    output logic                  we_o,
    output logic [AW-1:0]         rd_addr_o,
    output logic [DATA_WIDTH-1:0] rd_o,
    output logic                  load_pending_o,
    output logic [AW-1:0]         load_rd_addr_o,
    output logic                  err_o
);

    typedef enum logic {IDLE, LOAD_WAIT} state_t;

    state_t                state;
    logic [2:0]            ld_f3;
    logic [1:0]            ld_off;
    logic [7:0]            ld_byte;
    logic [15:0]           ld_half;
    logic [DATA_WIDTH-1:0] ld_data;
    logic                  ld_illegal;

    always_comb begin
        ld_illegal = 1'b0;
        case (ex_funct3_i)
            3'd0, 3'd4: ld_illegal = 1'b0;
            3'd1, 3'd5: ld_illegal = ex_byte_off_i[0];
            3'd2:       ld_illegal = (ex_byte_off_i != 2'd0);
            default:    ld_illegal = 1'b1;
        endcase
    end

    // Offset is captured at accept; the memory word arrives already word-aligned.
    always_comb begin
        ld_byte = mem_rdata_i[{ld_off, 3'b000} +: 8];
        ld_half = mem_rdata_i[{ld_off[1], 4'b0000} +: 16];
        ld_data = '0;
        case (ld_f3)
            3'd0:    ld_data = {{(DATA_WIDTH-8){ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{(DATA_WIDTH-16){ld_half[15]}}, ld_half};
            3'd2:    ld_data = mem_rdata_i;
            3'd4:    ld_data = {{(DATA_WIDTH-8){1'b0}}, ld_byte};
            3'd5:    ld_data = {{(DATA_WIDTH-16){1'b0}}, ld_half};
            default: ld_data = '0;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state          <= IDLE;
            ex_ready_o     <= 1'b1;
            we_o           <= 1'b0;
            rd_addr_o      <= '0;
            rd_o           <= '0;
            load_pending_o <= 1'b0;
            load_rd_addr_o <= '0;
            err_o          <= 1'b0;
            ld_f3          <= '0;
            ld_off         <= '0;
        end else begin
            we_o  <= 1'b0;
            err_o <= 1'b0;
            case (state)
                IDLE: begin
                    if (ex_valid_i) begin
                        if (!ex_is_load_i) begin
                            if (ex_wb_en_i && ex_rd_addr_i != '0) begin
                                we_o      <= 1'b1;
                                rd_addr_o <= ex_rd_addr_i;
                                rd_o      <= ex_result_i;
                            end
                        end else if (ld_illegal) begin
                            err_o <= 1'b1;
                        end else begin
                            ld_f3          <= ex_funct3_i;
                            ld_off         <= ex_byte_off_i;
                            load_rd_addr_o <= ex_rd_addr_i;
                            load_pending_o <= 1'b1;
                            ex_ready_o     <= 1'b0;
                            state          <= LOAD_WAIT;
                        end
                    end
                end
                LOAD_WAIT: begin
                    if (mem_rvalid_i) begin
                        load_pending_o <= 1'b0;
                        ex_ready_o     <= 1'b1;
                        state          <= IDLE;
                        if (mem_err_i) begin
                            err_o <= 1'b1;
                        end else if (load_rd_addr_o != '0) begin
                            we_o      <= 1'b1;
                            rd_addr_o <= load_rd_addr_o;
                            rd_o      <= ld_data;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_writeback_unit.sv
// Scoreboard bench for writeback_unit: stimulus pushes expected writes/errors,
// a negedge monitor pops and compares whenever we_o or err_o fires.
module tb_writeback_unit;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        ex_valid_i, ex_ready_o, ex_wb_en_i, ex_is_load_i;
    logic [2:0]  ex_funct3_i;
    logic [1:0]  ex_byte_off_i;
    logic [4:0]  ex_rd_addr_i;
    logic [31:0] ex_result_i;
    logic        mem_rvalid_i, mem_err_i;
    logic [31:0] mem_rdata_i;
    logic        we_o, load_pending_o, err_o;
    logic [4:0]  rd_addr_o, load_rd_addr_o;
    logic [31:0] rd_o;

    typedef struct {
        bit          is_err;
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    writeback_unit dut (
        .clk_i(clk), .rst_i(rst_i),
        .ex_valid_i(ex_valid_i), .ex_ready_o(ex_ready_o),
        .ex_wb_en_i(ex_wb_en_i), .ex_is_load_i(ex_is_load_i),
        .ex_funct3_i(ex_funct3_i), .ex_byte_off_i(ex_byte_off_i),
        .ex_rd_addr_i(ex_rd_addr_i), .ex_result_i(ex_result_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i), .mem_err_i(mem_err_i),
        .we_o(we_o), .rd_addr_o(rd_addr_o), .rd_o(rd_o),
        .load_pending_o(load_pending_o), .load_rd_addr_o(load_rd_addr_o),
        .err_o(err_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every we_o/err_o pulse must match the oldest expected event.
    always @(negedge clk) begin
        if (!rst_i && (we_o || err_o)) begin
            exp_t e;
            if (we_o && err_o) chk("we_err_overlap", 32'd1, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_output", {we_o, err_o}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("event_is_err", {31'd0, err_o}, {31'd0, e.is_err});
                if (!e.is_err) begin
                    chk("wb_addr", {27'd0, rd_addr_o}, {27'd0, e.addr});
                    chk("wb_data", rd_o, e.data);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input bit is_err, input logic [4:0] a, input logic [31:0] d);
        exp_t e;
        e.is_err = is_err; e.addr = a; e.data = d;
        exp_q.push_back(e);
    endtask

    task automatic alu(input logic [4:0] rd, input logic [31:0] res, input bit wb);
        ex_valid_i = 1'b1; ex_is_load_i = 1'b0; ex_wb_en_i = wb;
        ex_rd_addr_i = rd; ex_result_i = res;
        if (wb && rd != 5'd0) push(1'b0, rd, res);
        tick();
        ex_valid_i = 1'b0;
    endtask

    // Legal load: wait n cycles checking hazard outputs, then respond.
    task automatic load(input logic [2:0] f3, input logic [1:0] off, input logic [4:0] rd,
                        input logic [31:0] rdata, input int n, input bit merr,
                        input logic [31:0] exp_data);
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_wb_en_i = 1'b1;
        ex_funct3_i = f3; ex_byte_off_i = off; ex_rd_addr_i = rd; ex_result_i = 32'hDEADBEEF;
        tick();
        ex_valid_i = 1'b0;
        for (int i = 0; i < n; i++) begin
            chk("wait_ready", {31'd0, ex_ready_o}, 32'd0);
            chk("wait_pending", {31'd0, load_pending_o}, 32'd1);
            chk("wait_rd", {27'd0, load_rd_addr_o}, {27'd0, rd});
            tick();
        end
        mem_rvalid_i = 1'b1; mem_rdata_i = rdata; mem_err_i = merr;
        if (merr) push(1'b1, 5'd0, 32'd0);
        else if (rd != 5'd0) push(1'b0, rd, exp_data);
        tick();
        mem_rvalid_i = 1'b0; mem_err_i = 1'b0;
        chk("resp_ready", {31'd0, ex_ready_o}, 32'd1);
        chk("resp_pending", {31'd0, load_pending_o}, 32'd0);
    endtask

    task automatic bad_load(input logic [2:0] f3, input logic [1:0] off);
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_wb_en_i = 1'b1;
        ex_funct3_i = f3; ex_byte_off_i = off; ex_rd_addr_i = 5'd6;
        push(1'b1, 5'd0, 32'd0);
        tick();
        ex_valid_i = 1'b0;
        chk("bad_stays_idle", {30'd0, ex_ready_o, load_pending_o}, 32'd2);
    endtask

    task automatic chk_reset_state(input string name);
        chk(name, {ex_ready_o, we_o, err_o, load_pending_o, rd_addr_o, load_rd_addr_o},
            {1'b1, 3'b000, 10'd0});
        chk({name, "_data"}, rd_o, 32'd0);
    endtask

    initial begin
        rst_i = 1'b1; ex_valid_i = 1'b0; ex_wb_en_i = 1'b0; ex_is_load_i = 1'b0;
        ex_funct3_i = 3'd0; ex_byte_off_i = 2'd0; ex_rd_addr_i = 5'd0; ex_result_i = 32'd0;
        mem_rvalid_i = 1'b0; mem_rdata_i = 32'd0; mem_err_i = 1'b0;
        tick(); tick();
        chk_reset_state("reset_init");
        rst_i = 1'b0;
        tick();

        // Make outputs non-zero, then reset asynchronously mid-cycle.
        alu(5'd7, 32'h00000055, 1'b1);
        tick();
        #3 rst_i = 1'b1;
        #1 chk_reset_state("reset_async");
        tick();
        rst_i = 1'b0;
        tick();

        alu(5'd1, 32'h00000001, 1'b1);
        alu(5'd31, 32'hFFFFFFFF, 1'b1);
        alu(5'd0, 32'h12345678, 1'b1);
        alu(5'd4, 32'h0000BEEF, 1'b0);
        tick();

        load(3'd0, 2'd3, 5'd5, 32'h80FF7F01, 3, 1'b0, 32'hFFFFFF80);
        load(3'd4, 2'd3, 5'd5, 32'h80FF7F01, 3, 1'b0, 32'h00000080);
        load(3'd5, 2'd2, 5'd5, 32'h80FF7F01, 2, 1'b0, 32'h000080FF);
        load(3'd2, 2'd0, 5'd5, 32'h80FF7F01, 1, 1'b0, 32'h80FF7F01);
        load(3'd1, 2'd2, 5'd10, 32'h80FF7F01, 0, 1'b0, 32'hFFFF80FF);
        load(3'd0, 2'd1, 5'd11, 32'h80FF7F01, 1, 1'b0, 32'h0000007F);
        // Back-to-back: ALU accepted in the cycle the load data is written.
        alu(5'd12, 32'hCAFEF00D, 1'b1);
        load(3'd2, 2'd0, 5'd0, 32'h11112222, 1, 1'b0, 32'h0);

        bad_load(3'd2, 2'd2);
        bad_load(3'd3, 2'd0);
        bad_load(3'd1, 2'd1);
        load(3'd2, 2'd0, 5'd8, 32'hAAAA5555, 2, 1'b1, 32'h0);

        // Stray response in IDLE.
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h0BADF00D;
        tick();
        mem_rvalid_i = 1'b0;
        chk("stray_no_out", {30'd0, we_o, err_o}, 32'd0);

        // Abandoned load: reset during LOAD_WAIT, response after release.
        ex_valid_i = 1'b1; ex_is_load_i = 1'b1; ex_funct3_i = 3'd2;
        ex_byte_off_i = 2'd0; ex_rd_addr_i = 5'd9;
        tick();
        ex_valid_i = 1'b0;
        chk("abandon_pending", {31'd0, load_pending_o}, 32'd1);
        #3 rst_i = 1'b1;
        #1 chk("abandon_rst_ready", {30'd0, ex_ready_o, load_pending_o}, 32'd2);
        tick();
        rst_i = 1'b0;
        tick();
        mem_rvalid_i = 1'b1; mem_rdata_i = 32'h99999999;
        tick();
        mem_rvalid_i = 1'b0;
        chk("abandon_no_out", {30'd0, we_o, err_o}, 32'd0);

        tick(); tick();
        chk("queue_drained", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/writeback_unit.md
# writeback_unit

Writeback stage of the RV32I core: the single producer driving the `register_file` write port (`we_i`, `rd_addr_i`, `rd_i`). It accepts completed instructions from execute over a valid/ready handshake. ALU results are written directly. For loads, it waits for the data-memory response, then aligns and sign/zero-extends the data before writing. It also exports a pending-load indication for hazard detection.

## Interface
Parameters:
- `DATA_WIDTH`, default `pkg_config::DATA_WIDTH` (32): register data width.
- `NUM_REGISTER`, default `pkg_config::NUM_REGISTER` (32): register count; `AW = $clog2(NUM_REGISTER)`.

Ports:
- `clk_i`  in  1  clock; one clock domain, all flops on rising edge.
- `rst_i`  in  1  reset, asynchronous, active-high.
- `ex_valid_i`  in  1  execute presents an instruction.
- `ex_ready_o`  out  1  unit can accept; high only in IDLE.
- `ex_wb_en_i`  in  1  instruction writes rd.
- `ex_is_load_i`  in  1  instruction is a load.
- `ex_funct3_i`  in  3  load type: 0 LB, 1 LH, 2 LW, 4 LBU, 5 LHU.
- `ex_byte_off_i`  in  2  load address bits [1:0].
- `ex_rd_addr_i`  in  AW  destination register.
- `ex_result_i`  in  DATA_WIDTH  ALU result; ignored for loads.
- `mem_rvalid_i`  in  1  load response valid, one-cycle pulse.
- `mem_rdata_i`  in  DATA_WIDTH  aligned 32-bit memory word.
- `mem_err_i`  in  1  bus error, qualified by `mem_rvalid_i`.
- `we_o`  out  1  register file write enable.
- `rd_addr_o`  out  AW  register file write address.
- `rd_o`  out  DATA_WIDTH  register file write data.
- `load_pending_o`  out  1  a load is outstanding.
- `load_rd_addr_o`  out  AW  destination of the outstanding load.
- `err_o`  out  1  one-cycle pulse on a misaligned load, an illegal funct3, or a bus error.

## Operation
- **Reset values:** all outputs are registered and reset to 0; `ex_ready_o` = 1 (state IDLE).
- **FSM:**
  - **IDLE:** `ex_ready_o` = 1.
    - Accept when `ex_valid_i & ex_ready_o`.
    - Non-load: if `ex_wb_en_i` and `ex_rd_addr_i != 0`, the next cycle has `we_o` = 1, `rd_addr_o` = rd, `rd_o` = `ex_result_i`; otherwise there is no write. Stay in IDLE.
    - Load, legal: capture rd, funct3 and offset, then go to LOAD_WAIT.
    - Load, illegal: `err_o` pulses next cycle, no write, stay in IDLE. Illegal means:
      - funct3 is 3, 6 or 7; or
      - LH/LHU with `off[0]` = 1; or
      - LW with `off != 0`.
  - **LOAD_WAIT:** `ex_ready_o` = 0.
    - On `mem_rvalid_i` with `mem_err_i` = 0: the next cycle writes the extracted data (unless captured rd = 0), and the state returns to IDLE.
    - On `mem_rvalid_i` with `mem_err_i` = 1: `err_o` pulses next cycle, no write, return to IDLE.
- **Extraction:**
  - byte = `rdata[8*off +: 8]`
  - half = `rdata[16*off[1] +: 16]`
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the full word.
- `mem_rvalid_i` in IDLE is ignored: no write and no error.
- Writes to x0 are never issued (`we_o` stays 0). For x0 loads, the memory handshake still completes.
- When `we_o` = 0, `rd_addr_o`/`rd_o` hold their last values.
- **Reset mid-LOAD_WAIT:** the load is abandoned, and no write or `err_o` follows after reset release.

## Timing
- ALU writeback latency: 1 cycle from the accept edge to `we_o` high. Back-to-back ALU accepts give `we_o` high on consecutive cycles.
- Load latency: 1 cycle from the `mem_rvalid_i` edge to `we_o` high. `ex_ready_o` rises in the same cycle that `we_o` is high. The next accept happens at the earliest on that cycle.
- `load_pending_o` is high from the cycle after a load is accepted through the `mem_rvalid_i` cycle. It is low in the cycle `we_o` carries the load data. `load_rd_addr_o` is valid while `load_pending_o` = 1.
- `we_o` and `err_o` are never high in the same cycle; each is a single-cycle pulse per event.

## Test plan
- **Reset:** assert `rst_i` asynchronously mid-cycle -> all outputs 0 and `ex_ready_o` = 1 immediately.
- **Consecutive ALU writes:** accept ALU rd=1 result 0x00000001, then rd=31 result 0xFFFFFFFF on consecutive cycles -> `we_o` pulses on consecutive cycles with (1, 0x00000001), then (31, 0xFFFFFFFF). ALU rd=0 -> no `we_o`.
- **Load extension:**
  - Accept LB rd=5 off=3; respond with `mem_rdata_i` = 0x80FF7F01 after 3 wait cycles.
  - Required: `ex_ready_o` = 0 and `load_pending_o` = 1 with `load_rd_addr_o` = 5 during the wait. Next cycle after response, `we_o`=1, rd=5, data 0xFFFFFF80.
  - Repeat with LBU -> 0x00000080.
  - LHU off=2 -> 0x000080FF.
  - LW off=0 -> 0x80FF7F01.
- **Error cases:**
  - LW off=2 -> `err_o` pulse, no write, no LOAD_WAIT.
  - funct3=3 -> `err_o` pulse.
  - LW with `mem_err_i` = 1 on the response -> `err_o` pulse, no write, back in IDLE.
- **Stray response and abandoned load:**
  - `mem_rvalid_i` pulse in IDLE -> no write, no error.
  - Reset asserted during LOAD_WAIT, then `mem_rvalid_i` after release -> no write.
